// File: rtl/intersection_sequencer_pkg.sv
// Shared definitions for the intersection sequencer.
//   state_t      : FSM phase encoding, also driven out on Phase
//   SEL_*        : Cfg_Sel register-select codes
//   RED/GRN/YEL  : one-hot {Red,Green,Yellow} lamp encodings
//   main_lamp / side_lamp : lamp decode for each signal head
package intersection_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_MG  = 3'd0,
      ST_MY  = 3'd1,
      ST_AR1 = 3'd2,
      ST_SG  = 3'd3,
      ST_SY  = 3'd4,
      ST_PW  = 3'd5,
      ST_AR2 = 3'd6
   } state_t;

   localparam logic [2:0] SEL_MG = 3'd0;
   localparam logic [2:0] SEL_SG = 3'd1;
   localparam logic [2:0] SEL_Y  = 3'd2;
   localparam logic [2:0] SEL_AR = 3'd3;
   localparam logic [2:0] SEL_W  = 3'd4;

   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] GRN = 3'b010;
   localparam logic [2:0] YEL = 3'b001;

   function automatic logic [2:0] main_lamp(input state_t s);
      case (s)
         ST_MG:   return GRN;
         ST_MY:   return YEL;
         default: return RED;
      endcase
   endfunction

   function automatic logic [2:0] side_lamp(input state_t s);
      case (s)
         ST_SG:   return GRN;
         ST_SY:   return YEL;
         default: return RED;
      endcase
   endfunction

endpackage

// File: rtl/intersection_sequencer_phase_timer.sv
// Phase timer for the intersection sequencer.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   clear        : zero the count on the next edge (phase change)
//   saturate     : hold the count once it reaches limit
//   limit        : live phase duration the count is compared with
//   count        : cycles spent in the current phase
//   done         : count >= limit
module intersection_sequencer_phase_timer #(
   parameter int CNT_W = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             clear,
   input  logic             saturate,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             done
);

   // >= rather than == so a duration lowered below the running count
   // still ends the phase instead of waiting for a wrap.
   assign done = (count >= limit);

   always_ff @(posedge Clock) begin
      if (Reset || clear) begin
         count <= '0;
      end else if (saturate && done) begin
         count <= count;
      end else if (count != {CNT_W{1'b1}}) begin
         // Stops at all-ones instead of wrapping back to zero.
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/intersection_sequencer.sv
// Demand-actuated phase sequencer for a Main/Side intersection with a
// pedestrian crossing.
//   Clock, Reset      : rising-edge clock, synchronous active-high reset
//   Side_Req          : Side-road vehicle sensor (level)
//   Ped_Req           : pedestrian button (any-width pulse, latched)
//   Cfg_Wr/Sel/Data   : duration register write port (Sel 5..7 ignored)
//   Main_RGY/Side_RGY : one-hot {Red,Green,Yellow} lamps per head
//   Walk              : pedestrian walk lamp
//   Ped_Ack           : one-cycle pulse in the first walk cycle
//   Phase             : current FSM state (status/debug)
// A duration value D gives a phase of D+1 cycles.
module intersection_sequencer
   import intersection_sequencer_pkg::*;
#(
   parameter int CNT_W = 4,
   parameter int D_MG  = 7,
   parameter int D_SG  = 4,
   parameter int D_Y   = 1,
   parameter int D_AR  = 0,
   parameter int D_W   = 3
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             Side_Req,
   input  logic             Ped_Req,
   input  logic             Cfg_Wr,
   input  logic [2:0]       Cfg_Sel,
   input  logic [CNT_W-1:0] Cfg_Data,
   output logic [2:0]       Main_RGY,
   output logic [2:0]       Side_RGY,
   output logic             Walk,
   output logic             Ped_Ack,
   output logic [2:0]       Phase
);

   state_t           state, next_state;
   logic [CNT_W-1:0] d_mg, d_sg, d_y, d_ar, d_w;
   logic [CNT_W-1:0] limit, count;
   logic             done;
   logic             ped_pending, last_ped;
   logic             state_change, enter_pw, enter_sg;

   // ---------------- duration registers ----------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         d_mg <= CNT_W'(D_MG);
         d_sg <= CNT_W'(D_SG);
         d_y  <= CNT_W'(D_Y);
         d_ar <= CNT_W'(D_AR);
         d_w  <= CNT_W'(D_W);
      end else if (Cfg_Wr) begin
         case (Cfg_Sel)
            SEL_MG:  d_mg <= Cfg_Data;
            SEL_SG:  d_sg <= Cfg_Data;
            SEL_Y:   d_y  <= Cfg_Data;
            SEL_AR:  d_ar <= Cfg_Data;
            SEL_W:   d_w  <= Cfg_Data;
            default: ;
         endcase
      end
   end

   // The running phase always compares against the live register.
   always_comb begin
      limit = d_mg;
      case (state)
         ST_MG:         limit = d_mg;
         ST_MY, ST_SY:  limit = d_y;
         ST_AR1, ST_AR2: limit = d_ar;
         ST_SG:         limit = d_sg;
         ST_PW:         limit = d_w;
         default:       limit = d_mg;
      endcase
   end

   intersection_sequencer_phase_timer #(.CNT_W(CNT_W)) u_timer (
      .Clock    (Clock),
      .Reset    (Reset),
      .clear    (state_change),
      .saturate (state == ST_MG),
      .limit    (limit),
      .count    (count),
      .done     (done)
   );

   // ---------------- FSM ----------------
   always_ff @(posedge Clock) begin
      if (Reset) state <= ST_MG;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_MG:  if (done && (Side_Req || ped_pending)) next_state = ST_MY;
         ST_MY:  if (done) next_state = ST_AR1;
         ST_AR1: begin
            if (done) begin
               // Tie goes to whichever was not served last; with no demand
               // left the Side road is served anyway.
               if (ped_pending && Side_Req) next_state = last_ped ? ST_SG : ST_PW;
               else if (ped_pending)        next_state = ST_PW;
               else                         next_state = ST_SG;
            end
         end
         ST_SG:  if (done) next_state = ST_SY;
         ST_SY:  if (done) next_state = ST_AR2;
         ST_PW:  if (done) next_state = ST_AR2;
         ST_AR2: if (done) next_state = ST_MG;
         default: next_state = ST_MG;
      endcase
   end

   assign state_change = (next_state != state);
   assign enter_pw     = (next_state == ST_PW) && (state != ST_PW);
   assign enter_sg     = (next_state == ST_SG) && (state != ST_SG);

   // ---------------- request latches ----------------
   always_ff @(posedge Clock) begin
      if (Reset) begin
         ped_pending <= 1'b0;
         last_ped    <= 1'b0;
      end else begin
         // A press in the same cycle as the clear re-arms the request.
         if (Ped_Req)       ped_pending <= 1'b1;
         else if (enter_pw) ped_pending <= 1'b0;
         if (enter_pw)      last_ped <= 1'b1;
         else if (enter_sg) last_ped <= 1'b0;
      end
   end

   // ---------------- registered Moore outputs ----------------
   // Decoded from next_state so lamps change together with the state.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         Main_RGY <= GRN;
         Side_RGY <= RED;
         Walk     <= 1'b0;
         Ped_Ack  <= 1'b0;
         Phase    <= ST_MG;
      end else begin
         Main_RGY <= main_lamp(next_state);
         Side_RGY <= side_lamp(next_state);
         Walk     <= (next_state == ST_PW);
         Ped_Ack  <= enter_pw;
         Phase    <= next_state;
      end
   end

endmodule

// File: tb/tb_intersection_sequencer.sv
module tb_intersection_sequencer;
   import intersection_sequencer_pkg::*;

   localparam int CNT_W = 4;

   logic             Clock = 1'b0;
   logic             Reset;
   logic             Side_Req, Ped_Req, Cfg_Wr;
   logic [2:0]       Cfg_Sel;
   logic [CNT_W-1:0] Cfg_Data;
   logic [2:0]       Main_RGY, Side_RGY, Phase;
   logic             Walk, Ped_Ack;

   int n_cmp = 0;
   int n_bad = 0;

   intersection_sequencer dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .Side_Req (Side_Req),
      .Ped_Req  (Ped_Req),
      .Cfg_Wr   (Cfg_Wr),
      .Cfg_Sel  (Cfg_Sel),
      .Cfg_Data (Cfg_Data),
      .Main_RGY (Main_RGY),
      .Side_RGY (Side_RGY),
      .Walk     (Walk),
      .Ped_Ack  (Ped_Ack),
      .Phase    (Phase)
   );

   // ---------------- clock ----------------
   always #5 Clock = ~Clock;

   // ---------------- vector table ----------------
   typedef struct {
      string      tag;
      int         cyc;
      logic       side;
      logic       ped;
      logic [2:0] phase;
      logic       ack;
   } vec_t;

   vec_t vecs[$];

   // Expected lamps per phase, written from the lamp table.
   function automatic logic [2:0] exp_main(input logic [2:0] p);
      if (p == 3'(ST_MG)) return 3'b010;
      if (p == 3'(ST_MY)) return 3'b001;
      return 3'b100;
   endfunction

   function automatic logic [2:0] exp_side(input logic [2:0] p);
      if (p == 3'(ST_SG)) return 3'b010;
      if (p == 3'(ST_SY)) return 3'b001;
      return 3'b100;
   endfunction

   // Appends n consecutive cycles with the same inputs and expected phase.
   task automatic add(input string tag, input int n, input logic side,
                      input logic ped, input state_t ph);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.tag = tag; v.cyc = vecs.size(); v.side = side; v.ped = ped;
         v.phase = ph; v.ack = 1'b0;
         vecs.push_back(v);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic check(input string name, input int cyc,
                        input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
      end
   endtask

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   // Leaves the bench in cycle 0: first cycle after reset, inputs idle.
   task automatic do_reset();
      Reset = 1'b1; Side_Req = 1'b0; Ped_Req = 1'b0;
      Cfg_Wr = 1'b0; Cfg_Sel = '0; Cfg_Data = '0;
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
   endtask

   task automatic check_phase(input string name, input int cyc, input state_t ph);
      check({name, "_phase"}, cyc, {5'd0, Phase}, {5'd0, 3'(ph)});
   endtask

   task automatic check_safety(input int cyc);
      check("safety_heads", cyc, {7'd0, (Main_RGY != 3'b100) && (Side_RGY != 3'b100)}, 8'd0);
      check("safety_walk", cyc, {7'd0, Walk && ((Main_RGY != 3'b100) || (Side_RGY != 3'b100))}, 8'd0);
   endtask

   task automatic run_table();
      for (int i = 0; i < vecs.size(); i++) begin
         Side_Req = vecs[i].side;
         Ped_Req  = vecs[i].ped;
         check({vecs[i].tag, "_phase"}, vecs[i].cyc, {5'd0, Phase}, {5'd0, vecs[i].phase});
         check({vecs[i].tag, "_main"},  vecs[i].cyc, {5'd0, Main_RGY}, {5'd0, exp_main(vecs[i].phase)});
         check({vecs[i].tag, "_side"},  vecs[i].cyc, {5'd0, Side_RGY}, {5'd0, exp_side(vecs[i].phase)});
         check({vecs[i].tag, "_walk"},  vecs[i].cyc, {7'd0, Walk}, {7'd0, vecs[i].phase == 3'(ST_PW)});
         check({vecs[i].tag, "_ack"},   vecs[i].cyc, {7'd0, Ped_Ack}, {7'd0, vecs[i].ack});
         step();
      end
      vecs.delete();
   endtask

   // ---------------- test sequence ----------------
   initial begin
      // Idle: no demand for 30 cycles, Main stays green.
      do_reset();
      add("idle", 30, 1'b0, 1'b0, ST_MG);
      run_table();

      // Side demand from cycle 2: full default Side cycle back to MG at 19.
      do_reset();
      add("side", 2, 1'b0, 1'b0, ST_MG);
      add("side", 6, 1'b1, 1'b0, ST_MG);
      add("side", 2, 1'b1, 1'b0, ST_MY);
      add("side", 1, 1'b1, 1'b0, ST_AR1);
      add("side", 5, 1'b1, 1'b0, ST_SG);
      add("side", 2, 1'b1, 1'b0, ST_SY);
      add("side", 1, 1'b1, 1'b0, ST_AR2);
      add("side", 2, 1'b1, 1'b0, ST_MG);
      run_table();

      // One-cycle press at cycle 3: walk 11..14, ack at 11, MG at 16.
      do_reset();
      add("ped", 3, 1'b0, 1'b0, ST_MG);
      add("ped", 1, 1'b0, 1'b1, ST_MG);
      add("ped", 4, 1'b0, 1'b0, ST_MG);
      add("ped", 2, 1'b0, 1'b0, ST_MY);
      add("ped", 1, 1'b0, 1'b0, ST_AR1);
      add("ped", 4, 1'b0, 1'b0, ST_PW);
      add("ped", 1, 1'b0, 1'b0, ST_AR2);
      add("ped", 2, 1'b0, 1'b0, ST_MG);
      vecs[11].ack = 1'b1;
      run_table();

      // Tie arbitration: ped first, then Side; the press during the ack
      // cycle keeps a request pending, so the third AR1 exit is PW again.
      do_reset();
      for (int c = 0; c <= 47; c++) begin
         Side_Req = 1'b1;
         Ped_Req  = (c == 1) || (c == 11);
         check_safety(c);
         if (c == 11 || c == 46) begin
            check_phase("tie_pw", c, ST_PW);
            check("tie_ack", c, {7'd0, Ped_Ack}, 8'd1);
         end
         if (c == 12) check("tie_ack_off", c, {7'd0, Ped_Ack}, 8'd0);
         if (c == 16) check_phase("tie_mg", c, ST_MG);
         if (c == 27) check_phase("tie_sg", c, ST_SG);
         if (c == 35) check_phase("tie_mg2", c, ST_MG);
         if (c == 45) check_phase("tie_ar1", c, ST_AR1);
         step();
      end
      Ped_Req = 1'b0;

      // Yellow lengthened live to 3 during MY at cnt 0; select 6 ignored.
      do_reset();
      for (int c = 0; c <= 23; c++) begin
         Side_Req = 1'b1;
         Cfg_Wr   = (c == 8) || (c == 9);
         Cfg_Sel  = (c == 8) ? SEL_Y : 3'd6;
         Cfg_Data = (c == 8) ? 4'd3 : 4'd0;
         check_safety(c);
         if (c == 8)  check_phase("cfg_my0", c, ST_MY);
         if (c == 11) check_phase("cfg_my3", c, ST_MY);
         if (c == 12) check_phase("cfg_ar1", c, ST_AR1);
         if (c == 17) check_phase("cfg_sg", c, ST_SG);
         if (c == 21) check_phase("cfg_sy", c, ST_SY);
         if (c == 22) check_phase("cfg_ar2", c, ST_AR2);
         if (c == 23) check_phase("cfg_mg", c, ST_MG);
         step();
      end
      Cfg_Wr = 1'b0;

      // Reset in the third SG cycle wins over a pending press and a write;
      // durations return to defaults and the press is not served.
      do_reset();
      for (int c = 0; c <= 8; c++) begin
         Side_Req = 1'b1;
         Cfg_Wr   = (c == 0) || (c == 8);
         Cfg_Sel  = SEL_MG;
         Cfg_Data = (c == 0) ? 4'd2 : 4'd1;
         Ped_Req  = (c == 7) || (c == 8);
         Reset    = (c == 8);
         if (c == 3) check_phase("rst_my", c, ST_MY);
         if (c == 6) check_phase("rst_sg1", c, ST_SG);
         if (c == 8) check_phase("rst_sg3", c, ST_SG);
         step();
      end
      Reset = 1'b0; Cfg_Wr = 1'b0; Ped_Req = 1'b0;
      for (int c = 0; c <= 11; c++) begin
         Side_Req = 1'b1;
         if (c == 0) begin
            check("rst_main", c, {5'd0, Main_RGY}, 8'b010);
            check("rst_side", c, {5'd0, Side_RGY}, 8'b100);
            check("rst_walk", c, {7'd0, Walk}, 8'd0);
            check("rst_ack", c, {7'd0, Ped_Ack}, 8'd0);
            check_phase("rst_mg0", c, ST_MG);
         end
         if (c == 7)  check_phase("rst_mg7", c, ST_MG);
         if (c == 8)  check_phase("rst_my8", c, ST_MY);
         if (c == 10) check_phase("rst_ar1", c, ST_AR1);
         if (c == 11) check_phase("rst_sg_no_ped", c, ST_SG);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/intersection_sequencer.md
# intersection_sequencer

Phase sequencer for a two-road intersection (Main/Side) with a pedestrian crossing. It owns a phase timer and a state machine, and arbitrates between Side-road vehicle demand and pedestrian demand. It drives both signal heads and the Walk lamp, and holds five runtime-programmable phase durations. It sits above the per-head light outputs and replaces the fixed-cycle light controller wherever demand-actuated operation is required.

## Interface
- CNT_W, 4: width of phase timer and duration registers
- D_MG, 7: Main green minimum duration reset value
- D_SG, 4: Side green duration reset value
- D_Y, 1: yellow duration reset value (both heads)
- D_AR, 0: all-red clearance duration reset value
- D_W, 3: pedestrian walk duration reset value

Ports:
- Clock  in  1  clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Side_Req  in  1  Side-road vehicle sensor, level
- Ped_Req  in  1  pedestrian button, any-width pulse
- Cfg_Wr  in  1  duration register write strobe
- Cfg_Sel  in  3  register select: 0 MG, 1 SG, 2 Y, 3 AR, 4 W; 5–7 ignored
- Cfg_Data  in  CNT_W  duration value
- Main_RGY  out  3  {Red,Green,Yellow}, one-hot
- Side_RGY  out  3  {Red,Green,Yellow}, one-hot
- Walk  out  1  pedestrian walk lamp
- Ped_Ack  out  1  one-cycle pulse, pedestrian request accepted
- Phase  out  3  current state encoding (status)

## Operation
- States: MG, MY, AR1, SG, SY, PW, AR2.
- Lamps per state:
  - MG: Main 010, Side 100
  - MY: Main 001, Side 100
  - SG: Main 100, Side 010
  - SY: Main 100, Side 001
  - AR1, AR2, PW: both 100
  - Walk=1 only in PW
- Duration value D gives a phase of D+1 cycles. D=0 is legal and gives a 1-cycle phase.
- Phase timer:
  - Clears to 0 on every state change, otherwise increments.
  - In MG it saturates at D_MG.
  - It never wraps.
- Transitions:
  - MG→MY when cnt==D_MG and (Side_Req or ped_pending). Otherwise MG holds indefinitely.
  - MY→AR1 when cnt==D_Y.
  - AR1 at cnt==D_AR goes to PW or SG, chosen by arbitration.
  - SG→SY at D_SG.
  - SY→AR2 at D_Y.
  - PW→AR2 at D_W.
  - AR2→MG at D_AR.
- Arbitration at AR1 exit:
  - Only ped_pending → PW.
  - Only Side_Req → SG.
  - Both → serve the one not served last (last_ped flag: set on entry to PW, cleared on entry to SG; reset 0, so ped wins the first tie).
  - Neither (Side_Req dropped during MY/AR1) → SG anyway. The yellow is never aborted.
- ped_pending:
  - Set by Ped_Req=1 in any cycle.
  - Cleared on the edge entering PW.
  - Ped_Req high during the first PW cycle sets it again (set wins).
- Ped_Ack=1 exactly in the first PW cycle.
- Duration registers:
  - Written on Cfg_Wr edge.
  - The running phase compares against the live register, so a write takes effect immediately.
  - If the new value is below the current cnt, the phase ends at saturation: MG compares with cnt>=D; all other phases also use >=.
  - Cfg_Sel 5–7: no effect.

## Timing
- Reset state: state MG, cnt 0, Main_RGY=010, Side_RGY=100, Walk=0, Ped_Ack=0, Phase=MG, ped_pending=0, last_ped=0.
- All duration registers return to their parameter values on reset.
- Outputs are registered Moore decodes of state. They change in the first cycle of the new phase.
- Request to response: a Side_Req seen at cnt>=D_MG leaves MG on the next edge. Minimum latency is 1 cycle to MY.
- Full default Side cycle: MG 8 + MY 2 + AR1 1 + SG 5 + SY 2 + AR2 1 = 19 cycles back to MG.
- Reset mid-operation: Reset wins over every transition, pending request and config write in that cycle.
- There is never a cycle with both heads non-red. Walk=1 only while both heads are red.

## Structure
- Shared package holds:
  - state enum (3 bits)
  - Cfg_Sel constants
  - RGY encodings RED=3'b100, GRN=3'b010, YEL=3'b001
- One sub-module: phase_timer. It has a clear input, a saturate-at-limit input, a CNT_W count output and a done output (cnt>=limit).
- FSM, arbitration flags, ped latch and config registers live in the top.

## Test plan
- Reset, Side_Req=0, Ped_Req=0 for 30 cycles → Main_RGY=010 throughout, Side_RGY=100, Walk=0.
- Side_Req=1 held from cycle 2 after reset → MY at cycle 8, AR1 at 10, SG cycles 11–15, SY 16–17, AR2 18, MG at 19.
- 1-cycle Ped_Req at cycle 3 → Ped_Ack pulse at cycle 11, Walk=1 cycles 11–14, both heads 100, MG at 16.
- Ped_Req and Side_Req both pending on two successive AR1 exits → first PW, then SG. A ped press during the Ped_Ack cycle leaves ped_pending=1.
- During MY, write Cfg_Sel=2, Cfg_Data=3 at cnt=0 → this yellow lasts 4 cycles. Writing Cfg_Sel=6 changes nothing.
- Assert Reset in the third SG cycle → the next cycle shows MG lamps, Ped_Ack=0, durations back to defaults, no pending request served.
